// File: rtl/dmrs_pkg.sv
// Shared types, constants and helpers for the low-PAPR DMRS sequence generator.
// Trig tables are stored at Q1.14 scale and rescaled to IQ_W in dmrs_phase_to_iq.
package dmrs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int SEQ_LEN_DEF = 6;
    localparam int PHASE_MOD   = 24;

    // round(cos/sin(k*pi/12) * 2^14), k = 0..23
    localparam int COS_TAB [PHASE_MOD] = '{
         16384,  15826,  14189,  11585,   8192,   4240,
             0,  -4240,  -8192, -11585, -14189, -15826,
        -16384, -15826, -14189, -11585,  -8192,  -4240,
             0,   4240,   8192,  11585,  14189,  15826
    };
    localparam int SIN_TAB [PHASE_MOD] = '{
             0,   4240,   8192,  11585,  14189,  15826,
         16384,  15826,  14189,  11585,   8192,   4240,
             0,  -4240,  -8192, -11585, -14189, -15826,
        -16384, -15826, -14189, -11585,  -8192,  -4240
    };

    function automatic logic signed [2:0] phi_to_signed(input logic [1:0] code);
        case (code)
            2'b00:   return 3'sd1;
            2'b01:   return 3'sd3;
            2'b10:   return -3'sd1;
            default: return -3'sd3;
        endcase
    endfunction

    // Valid for x < 2*PHASE_MOD.
    function automatic logic [4:0] mod24(input logic [5:0] x);
        if (x >= 6'(PHASE_MOD))
            return 5'(x - 6'(PHASE_MOD));
        return x[4:0];
    endfunction

endpackage

// File: rtl/dmrs_phase_to_iq.sv
// Pipeline stage 2: registered phase index -> signed I/Q via the constant trig tables.
module dmrs_phase_to_iq
    import dmrs_pkg::*;
#(
    parameter int IQ_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adv,
    input  logic                   p_valid,
    input  logic [4:0]             p,
    output logic signed [IQ_W-1:0] out_i,
    output logic signed [IQ_W-1:0] out_q,
    output logic                   out_valid
);

    localparam int SH  = (IQ_W >= 16) ? IQ_W - 16 : 16 - IQ_W;
    localparam int RND = (IQ_W < 16) ? (2 ** SH) / 2 : 0;

    int cos_v;
    int sin_v;

    always_comb begin
        cos_v = COS_TAB[p];
        sin_v = SIN_TAB[p];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= p_valid;
            if (IQ_W >= 16) begin
                out_i <= IQ_W'(cos_v <<< SH);
                out_q <= IQ_W'(sin_v <<< SH);
            end else begin
                out_i <= IQ_W'((cos_v + RND) >>> SH);
                out_q <= IQ_W'((sin_v + RND) >>> SH);
            end
        end
    end

endmodule

// File: rtl/dmrs_lowpapr_gen.sv
// Low-PAPR DMRS generator: walks the phase table, applies cyclic shift, emits I/Q.
// Cyclic shift is built only with DMRS_CYCLIC_SHIFT_EN defined; otherwise cs_in is ignored.
//
//   state | meaning
//   IDLE  | waiting for start; config latched on accept
//   RUN   | stepping counter/pass count, feeding stage 1
//   DRAIN | pipeline emptying; leaves on final transfer
module dmrs_lowpapr_gen
    import dmrs_pkg::*;
#(
    parameter int IQ_W    = 16,
    parameter int SEQ_LEN = SEQ_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4:0]             u_in,
    input  logic [3:0]             cs_in,
    input  logic [3:0]             rep_in,
    output logic [4:0]             u,
    output logic [9:0]             counter,
    input  logic [1:0]             phi_value,
    output logic signed [IQ_W-1:0] out_i,
    output logic signed [IQ_W-1:0] out_q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    state_t     state;
    logic [3:0] rep_r;
    logic [3:0] pass_cnt;
    logic [4:0] p1;
    logic       s1_valid;
    logic       adv;
    logic       last_n;
    logic [4:0] phase_off;
    logic [4:0] base3;
    logic [4:0] p_next;
    logic signed [2:0] phi_s;

    assign adv    = !out_valid || out_ready;
    assign last_n = (counter == 10'(SEQ_LEN - 1));

`ifdef DMRS_CYCLIC_SHIFT_EN
    logic [3:0] cs_r;
    logic [4:0] acc;
    logic [4:0] step;

    assign step      = mod24({1'b0, cs_r, 1'b0});
    assign phase_off = acc;

    // acc tracks 2*cs*n mod 24 without a multiplier; zero at every pass start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_r <= '0;
            acc  <= '0;
        end else begin
            if (state == IDLE && start)
                cs_r <= cs_in;
            if (state != RUN)
                acc <= '0;
            else if (adv)
                acc <= last_n ? 5'd0 : mod24({1'b0, acc} + {1'b0, step});
        end
    end
`else
    logic unused_cs;
    assign unused_cs = ^cs_in;
    assign phase_off = 5'd0;
`endif

    always_comb begin
        phi_s  = phi_to_signed(phi_value);
        base3  = mod24(6'(PHASE_MOD + 3 * int'(phi_s)));
        p_next = mod24({1'b0, base3} + {1'b0, phase_off});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= '0;
            u        <= '0;
            rep_r    <= '0;
            pass_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= RUN;
                    busy     <= 1'b1;
                    u        <= u_in;
                    rep_r    <= rep_in;
                    counter  <= '0;
                    pass_cnt <= '0;
                end
                RUN: if (adv) begin
                    if (!last_n)
                        counter <= counter + 10'd1;
                    else if (pass_cnt == rep_r)
                        state <= DRAIN;
                    else begin
                        counter  <= '0;
                        pass_cnt <= pass_cnt + 4'd1;
                    end
                end
                DRAIN: if (out_valid && out_ready && !s1_valid) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1       <= '0;
            s1_valid <= 1'b0;
        end else if (adv) begin
            p1       <= p_next;
            s1_valid <= (state == RUN);
        end
    end

    dmrs_phase_to_iq #(.IQ_W(IQ_W)) u_iq (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .p_valid   (s1_valid),
        .p         (p1),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_dmrs_lowpapr_gen.sv
// Self-checking bench for dmrs_lowpapr_gen: trig-based reference model, random backpressure.
module tb_dmrs_lowpapr_gen;

    localparam int IQ_W    = 16;
    localparam int SEQ_LEN = 6;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [4:0]             u_in = '0;
    logic [3:0]             cs_in = '0;
    logic [3:0]             rep_in = '0;
    logic [4:0]             u;
    logic [9:0]             counter;
    logic [1:0]             phi_value;
    logic signed [IQ_W-1:0] out_i;
    logic signed [IQ_W-1:0] out_q;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic                   busy;
    logic                   done;

    dmrs_lowpapr_gen #(.IQ_W(IQ_W), .SEQ_LEN(SEQ_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .u_in      (u_in),
        .cs_in     (cs_in),
        .rep_in    (rep_in),
        .u         (u),
        .counter   (counter),
        .phi_value (phi_value),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Phase table stand-in: returns a code for (u, n) in the same cycle.
    logic [1:0] tab [30][SEQ_LEN];
    always_comb begin
        phi_value = 2'b00;
        if (counter < SEQ_LEN && u < 30)
            phi_value = tab[int'(u)][int'(counter)];
    end

    typedef struct {int i; int q;} samp_t;
    samp_t expq[$];

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic int phi_dec(input logic [1:0] c);
        case (c)
            2'b00:   return 1;
            2'b01:   return 3;
            2'b10:   return -1;
            default: return -3;
        endcase
    endfunction

    task automatic push_run(input int uu, input int cs, input int rep);
        int   cs_eff;
        int   p;
        real  ang;
        real  scale;
        samp_t s;
`ifdef DMRS_CYCLIC_SHIFT_EN
        cs_eff = cs;
`else
        cs_eff = 0;
`endif
        scale = 2.0 ** (IQ_W - 2);
        for (int pass = 0; pass <= rep; pass++)
            for (int n = 0; n < SEQ_LEN; n++) begin
                p   = ((3 * phi_dec(tab[uu][n]) + 2 * cs_eff * n) % 24 + 24) % 24;
                ang = 3.14159265358979 * p / 12.0;
                s.i = rnd($cos(ang) * scale);
                s.q = rnd($sin(ang) * scale);
                expq.push_back(s);
            end
    endtask

    int   cyc = 0;
    always @(posedge clk) cyc++;

    bit   ready_rnd = 1'b0;
    always @(posedge clk) begin
        #1;
        out_ready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int   xfers, wraps, max_cnt, first_i, first_q, first_valid_cyc;
    bit   first_seen, got_first = 1'b1;
    bit   exp_done = 1'b0, prev_stall = 1'b0, prev_busy = 1'b0;
    logic signed [IQ_W-1:0] prev_i, prev_q;
    logic [9:0] prev_cnt;

    always @(negedge clk) begin
        samp_t s;
        if (rst) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (exp_done || done)
                check("done_pulse", done, exp_done);
            if (prev_stall)
                check("stall_hold", {out_valid, out_i, out_q}, {1'b1, prev_i, prev_q});
            exp_done = 1'b0;
            if (busy && prev_busy && prev_cnt == SEQ_LEN - 1 && counter == 0)
                wraps++;
            if (busy && int'(counter) > max_cnt)
                max_cnt = int'(counter);
            if (out_valid && !got_first) begin
                got_first       = 1'b1;
                first_valid_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0)
                    check("extra_xfer", 1, 0);
                else begin
                    s = expq.pop_front();
                    check("out_i", out_i, s.i);
                    check("out_q", out_q, s.q);
                    xfers++;
                    if (!first_seen) begin
                        first_seen = 1'b1;
                        first_i    = out_i;
                        first_q    = out_q;
                    end
                    exp_done = (expq.size() == 0);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_i     = out_i;
            prev_q     = out_q;
            prev_cnt   = counter;
            prev_busy  = busy;
        end
    end

    // Runs one generation; returns at the cycle where done is high.
    task automatic run(input int uu, input int cs, input int rep,
                       input bit rnd_ready, input bit b2b, input bit inject);
        int start_cyc;
        bit seen_done = 1'b0;
        ready_rnd = rnd_ready;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        u_in       = 5'(uu);
        cs_in      = 4'(cs);
        rep_in     = 4'(rep);
        start      = 1'b1;
        start_cyc  = cyc;
        xfers      = 0;
        wraps      = 0;
        max_cnt    = 0;
        first_seen = 1'b0;
        got_first  = 1'b0;
        push_run(uu, cs, rep);
        @(posedge clk);
        #1;
        start  = 1'b0;
        u_in   = 5'($urandom_range(0, 29));
        cs_in  = 4'($urandom_range(0, 11));
        rep_in = 4'($urandom_range(0, 15));
        for (int k = 0; k < 2000; k++) begin
            if (inject && k == 4) begin
                u_in   = 5'((uu + 1) % 30);
                rep_in = 4'(15);
                start  = 1'b1;
            end else
                start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!seen_done)
            check("done_timeout", 0, 1);
        check("xfer_count", xfers, SEQ_LEN * (rep + 1));
        check("counter_wraps", wraps, rep);
        check("counter_max", max_cnt, SEQ_LEN - 1);
        check("first_latency", first_valid_cyc - start_cyc, 3);
        check("u_latched", u, uu);
    endtask

    task automatic reset_test();
        bit hit = 1'b0;
        ready_rnd = 1'b0;
        @(posedge clk);
        #1;
        u_in       = 5'd5;
        cs_in      = 4'd2;
        rep_in     = 4'd0;
        start      = 1'b1;
        xfers      = 0;
        first_seen = 1'b1;
        got_first  = 1'b1;
        push_run(5, 2, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (xfers >= 2 && out_valid) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit)
            check("rst_reach_3rd", 0, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async", {out_valid, busy, done, out_i, out_q, counter, u}, 0);
        expq.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_no_done", {busy, out_valid, done}, 0);
    endtask

    initial begin
        int tmp [SEQ_LEN];
        for (int a = 0; a < 30; a++)
            for (int n = 0; n < SEQ_LEN; n++)
                tab[a][n] = 2'($urandom_range(0, 3));
        tmp = '{3, 2, 1, 1, 2, 3};
        for (int n = 0; n < SEQ_LEN; n++)
            tab[0][n] = 2'(tmp[n]);
        tab[2][0] = 2'b11;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {out_valid, busy, done, out_i, out_q, counter, u}, 0);
        rst = 1'b0;

        run(0, 0, 0, 1'b0, 1'b0, 1'b0);
        run(2, 3, 0, 1'b0, 1'b0, 1'b0);
        check("cs3_first_i", first_i, -11585);
        check("cs3_first_q", first_q, -11585);
        run(int'($urandom_range(0, 29)), int'($urandom_range(0, 11)), 2, 1'b1, 1'b0, 1'b0);
        run(7, 5, 1, 1'b1, 1'b0, 1'b1);
        run(9, 11, 0, 1'b0, 1'b0, 1'b0);
        run(11, 4, 1, 1'b1, 1'b1, 1'b0);
        reset_test();
        run(3, 4, 0, 1'b0, 1'b0, 1'b0);
        run(0, 7, 0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 6; t++)
            run(int'($urandom_range(0, 29)), int'($urandom_range(0, 11)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        repeat (5) @(posedge clk);
        check("queue_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmrs_lowpapr_gen.md
DMRS_LOWPAPR_GEN -- requirements
Module: dmrs_lowpapr_gen

Interface
REQ-001 SHALL have parameter IQ_W, default 16, I/Q sample width in signed Q1.(IQ_W-2) format.
REQ-002 SHALL have parameter SEQ_LEN, default 6, samples per sequence pass (phase-table depth).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin generation; sampled only in IDLE.
REQ-006 u_in  input  5  sequence-group number 0..29; latched on accepted start.
REQ-007 cs_in  input  4  cyclic-shift index 0..11; latched on accepted start.
REQ-008 rep_in  input  4  number of sequence passes minus 1 (1..16 passes); latched on accepted start.
REQ-009 u  output  5  latched sequence number driven to the phase table.
REQ-010 counter  output  10  sample index n driven to the phase table.
REQ-011 phi_value  input  2  phase code returned combinationally for (u, counter) in the same cycle.
REQ-012 out_i, out_q  output  IQ_W each  signed I and Q sample.
REQ-013 out_valid  output  1  sample valid.
REQ-014 out_ready  input  1  downstream accept; a transfer occurs when out_valid and out_ready are both 1.
REQ-015 busy  output  1  high from accepted start until the last sample transfers.
REQ-016 done  output  1  one-cycle pulse on the cycle after the last sample transfers.

Function
REQ-017 SHALL decode phi_value as follows: 00 = +1, 01 = +3, 10 = -1, 11 = -3 (units of pi/4).
REQ-018 SHALL form phase index p = (3*phi + 2*cs*n) mod 24, in units of pi/12.
REQ-019 SHALL compute 2*cs*n with a 5-bit modulo-24 accumulator that adds 2*cs per sample and clears to 0 at the start of each pass; no multiplier.
REQ-020 SHALL output out_i = round(cos(p*pi/12) * 2^(IQ_W-2)) and out_q = the sine equivalent, both from a 24-entry constant table.
REQ-021 SHALL be a 2-stage pipeline: stage 1 registers p; stage 2 registers I/Q and out_valid. The first sample is therefore valid 2 cycles after counter = 0.
REQ-022 SHALL use a global pipeline enable adv = !out_valid | out_ready; when adv = 0, counter, accumulator and both stages hold.
REQ-023 SHALL implement states IDLE, RUN and DRAIN.
  - IDLE -> RUN on start.
  - RUN -> DRAIN when counter = SEQ_LEN-1, the pass count = rep_in, and adv = 1.
  - DRAIN -> IDLE when the final sample transfers.
REQ-024 SHALL advance counter 0..SEQ_LEN-1 in RUN and wrap it to 0 while incrementing the pass count; counter SHALL never exceed SEQ_LEN-1.
REQ-025 SHALL ignore start while busy = 1; it is neither queued nor allowed to disturb latched config.
REQ-026 SHALL issue exactly SEQ_LEN*(rep_in+1) transfers per accepted start, with no duplicate or dropped sample under any out_ready pattern.
REQ-027 SHALL accept a new start in the same cycle done = 1; the first new sample appears 3 cycles later.
REQ-028 SHALL hold out_i, out_q and out_valid stable while out_valid = 1 and out_ready = 0.

Reset
REQ-029 On rst = 1 SHALL immediately reset as follows:
  - state = IDLE;
  - counter, u, accumulator and pass count = 0;
  - out_i, out_q = 0;
  - out_valid, busy, done = 0.
REQ-030 Reset asserted mid-operation SHALL abort the pass; no further samples or done pulse until a new start.

Configuration
REQ-031 With macro DMRS_CYCLIC_SHIFT_EN defined, cs_in SHALL be applied per REQ-018.
REQ-032 Without DMRS_CYCLIC_SHIFT_EN, cs_in SHALL be ignored and the accumulator removed, giving p = (3*phi) mod 24.

Structure
REQ-033 Package dmrs_pkg SHALL hold:
  - the state enum;
  - SEQ_LEN_DEF = 6 and PHASE_MOD = 24;
  - the phi-code-to-signed-value function;
  - the 24-entry cos/sin constant arrays.
REQ-034 SHALL instantiate one sub-module, dmrs_phase_to_iq: registered p -> I/Q lookup, forming stage 2.

Verification
REQ-035 u_in=0, cs_in=0, rep_in=0, out_ready=1, phi codes 11,10,01,01,10,11 -> p = 15,21,9,9,21,15; 6 valid cycles; done 1 cycle after the last transfer.
REQ-036 u_in=2, cs_in=3, rep_in=0 -> p(n) = (3*phi(n) + 6n) mod 24; n=0 phi=-3 -> p = 15, giving out_i = -11585, out_q = -11585 (IQ_W = 16).
REQ-037 rep_in=2, out_ready toggled randomly -> exactly 18 transfers, counter wraps 5 -> 0 twice, and outputs stay stable during stalls.
REQ-038 start pulsed while busy with a different u_in -> ignored; the output stream is unchanged.
REQ-039 rst asserted at the 3rd sample -> all outputs 0 asynchronously and no done; a new start then gives a clean 6-sample pass.
REQ-040 Build without DMRS_CYCLIC_SHIFT_EN, cs_in=7 -> output identical to the cs_in=0 run.
